// File: rtl/axis_framer_esc.sv
// Byte-stuffing AXI4-Stream framer: wraps each tlast-delimited packet as
// START [ID] payload STOP, escaping delimiter-valued bytes as ESC, byte^ESC_XOR.
module axis_framer_esc #(
    parameter logic [7:0] START_BYTE = 8'h7D,
    parameter logic [7:0] STOP_BYTE  = 8'h7E,
    parameter logic [7:0] ESC_BYTE   = 8'h7F,
    parameter logic [7:0] ESC_XOR    = 8'h20,
    parameter bit         ESCAPE_EN  = 1'b1,
    parameter bit         ID_EN      = 1'b0,
    parameter int         TID_WIDTH  = 4,
    parameter int         CNT_WIDTH  = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 target_tvalid,
    output logic                 target_tready,
    input  logic [7:0]           target_tdata,
    input  logic                 target_tlast,
    input  logic [TID_WIDTH-1:0] target_tid,
    output logic                 initiator_tvalid,
    input  logic                 initiator_tready,
    output logic [7:0]           initiator_tdata,
    output logic [CNT_WIDTH-1:0] stat_frames,
    output logic [CNT_WIDTH-1:0] stat_escapes,
    output logic [2:0]           o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ID   = 3'd1,
        S_DATA = 3'd2,
        S_ESC2 = 3'd3,
        S_STOP = 3'd4
    } state_t;

    state_t               r_state, w_next, r_ret, w_ret_next;
    logic                 r_tvalid, r_is_stop;
    logic [7:0]           r_tdata, r_id, r_hold, w_hold_next, w_byte, w_tid_ext;
    logic [CNT_WIDTH-1:0] r_frames, r_escapes;
    logic                 w_load, w_emit, w_esc, w_stop, w_latch_id, w_set_hold;

    function automatic logic is_special(input logic [7:0] b);
        return ESCAPE_EN && (b == START_BYTE || b == STOP_BYTE || b == ESC_BYTE);
    endfunction

    assign w_load           = !r_tvalid || initiator_tready;
    assign target_tready    = w_load && (r_state == S_DATA);
    assign initiator_tvalid = r_tvalid;
    assign initiator_tdata  = r_tdata;
    assign stat_frames      = r_frames;
    assign stat_escapes     = r_escapes;
    assign o_dbg_state      = r_state;

    always_comb begin
        w_tid_ext = '0;
        w_tid_ext[TID_WIDTH-1:0] = target_tid;
    end

    always_comb begin
        w_next      = r_state;
        w_emit      = 1'b0;
        w_byte      = '0;
        w_esc       = 1'b0;
        w_stop      = 1'b0;
        w_latch_id  = 1'b0;
        w_set_hold  = 1'b0;
        w_hold_next = r_hold;
        w_ret_next  = r_ret;
        if (w_load) begin
            case (r_state)
                S_IDLE: begin
                    // START goes out only once a beat is waiting, so frames are never empty
                    if (target_tvalid) begin
                        w_emit     = 1'b1;
                        w_byte     = START_BYTE;
                        w_latch_id = 1'b1;
                        w_next     = ID_EN ? S_ID : S_DATA;
                    end
                end
                S_ID: begin
                    w_emit = 1'b1;
                    w_next = S_DATA;
                    if (is_special(r_id)) begin
                        w_byte      = ESC_BYTE;
                        w_esc       = 1'b1;
                        w_set_hold  = 1'b1;
                        w_hold_next = r_id ^ ESC_XOR;
                        w_ret_next  = S_DATA;
                        w_next      = S_ESC2;
                    end else begin
                        w_byte = r_id;
                    end
                end
                S_DATA: begin
                    if (target_tvalid) begin
                        w_emit = 1'b1;
                        if (is_special(target_tdata)) begin
                            w_byte      = ESC_BYTE;
                            w_esc       = 1'b1;
                            w_set_hold  = 1'b1;
                            w_hold_next = target_tdata ^ ESC_XOR;
                            w_ret_next  = target_tlast ? S_STOP : S_DATA;
                            w_next      = S_ESC2;
                        end else begin
                            w_byte = target_tdata;
                            w_next = target_tlast ? S_STOP : S_DATA;
                        end
                    end
                end
                S_ESC2: begin
                    w_emit = 1'b1;
                    w_byte = r_hold;
                    w_next = r_ret;
                end
                S_STOP: begin
                    w_emit = 1'b1;
                    w_byte = STOP_BYTE;
                    w_stop = 1'b1;
                    w_next = S_IDLE;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state   <= S_IDLE;
            r_ret     <= S_DATA;
            r_tvalid  <= 1'b0;
            r_is_stop <= 1'b0;
            r_tdata   <= '0;
            r_id      <= '0;
            r_hold    <= '0;
            r_frames  <= '0;
            r_escapes <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch_id) r_id <= w_tid_ext;
            if (w_set_hold) begin
                r_hold <= w_hold_next;
                r_ret  <= w_ret_next;
            end
            if (w_load) begin
                r_tvalid  <= w_emit;
                r_is_stop <= w_stop;
                if (w_emit) r_tdata <= w_byte;
            end
            // A raw 7E payload byte (ESCAPE_EN=0) is not a frame end, hence the tag
            if (r_tvalid && initiator_tready && r_is_stop) r_frames <= r_frames + 1'b1;
            if (w_load && w_esc) r_escapes <= r_escapes + 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_framer_esc.sv
// Bench for axis_framer_esc: three instances (escaping, escaping+ID, legacy raw)
// checked against a frame-building reference model through an expected queue.
module tb_axis_framer_esc;

  localparam bit [2:0] ESC_EN_K = 3'b011;
  localparam bit [2:0] ID_EN_K  = 3'b010;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [2:0]  s_tvalid, s_tlast, s_tready, m_tvalid, m_ready;
  logic [7:0]  s_tdata[3], s_tid[3], m_tdata[3];
  logic [15:0] st_fr[3], st_esc[3];
  logic [2:0]  dbg[3];

  logic [7:0]  exp_q[$];
  logic [7:0]  pkt[$];
  int          hs_cyc[$];
  int          exp_frames[3], exp_esc[3];
  int          n_total = 0, n_bad = 0, cyc = 0;
  bit          rand_mode = 1'b0;
  bit          prev_stall[3];
  logic [7:0]  prev_data[3];

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  axis_framer_esc #(.ESCAPE_EN(1'b1), .ID_EN(1'b0), .TID_WIDTH(4)) dut0 (
    .aclk(aclk), .aresetn(aresetn),
    .target_tvalid(s_tvalid[0]), .target_tready(s_tready[0]), .target_tdata(s_tdata[0]),
    .target_tlast(s_tlast[0]), .target_tid(s_tid[0][3:0]),
    .initiator_tvalid(m_tvalid[0]), .initiator_tready(m_ready[0]), .initiator_tdata(m_tdata[0]),
    .stat_frames(st_fr[0]), .stat_escapes(st_esc[0]), .o_dbg_state(dbg[0]));

  axis_framer_esc #(.ESCAPE_EN(1'b1), .ID_EN(1'b1), .TID_WIDTH(8)) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .target_tvalid(s_tvalid[1]), .target_tready(s_tready[1]), .target_tdata(s_tdata[1]),
    .target_tlast(s_tlast[1]), .target_tid(s_tid[1]),
    .initiator_tvalid(m_tvalid[1]), .initiator_tready(m_ready[1]), .initiator_tdata(m_tdata[1]),
    .stat_frames(st_fr[1]), .stat_escapes(st_esc[1]), .o_dbg_state(dbg[1]));

  axis_framer_esc #(.ESCAPE_EN(1'b0), .ID_EN(1'b0), .TID_WIDTH(4)) dut2 (
    .aclk(aclk), .aresetn(aresetn),
    .target_tvalid(s_tvalid[2]), .target_tready(s_tready[2]), .target_tdata(s_tdata[2]),
    .target_tlast(s_tlast[2]), .target_tid(s_tid[2][3:0]),
    .initiator_tvalid(m_tvalid[2]), .initiator_tready(m_ready[2]), .initiator_tdata(m_tdata[2]),
    .stat_frames(st_fr[2]), .stat_escapes(st_esc[2]), .o_dbg_state(dbg[2]));

  // Handshake convention: a byte moves on the rising edge where valid && ready,
  // both sampled stable at the preceding falling edge.

  // ---------------- reference model ----------------
  task automatic put_byte(input int k, input logic [7:0] b);
    if (ESC_EN_K[k] && (b == 8'h7D || b == 8'h7E || b == 8'h7F)) begin
      exp_q.push_back(8'h7F);
      exp_q.push_back(b ^ 8'h20);
      exp_esc[k]++;
    end else begin
      exp_q.push_back(b);
    end
  endtask

  task automatic push_frame(input int k, input logic [7:0] tid);
    exp_q.push_back(8'h7D);
    if (ID_EN_K[k]) put_byte(k, tid);
    foreach (pkt[i]) put_byte(k, pkt[i]);
    exp_q.push_back(8'h7E);
    exp_frames[k]++;
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_stats(input int k);
    chk($sformatf("stat_frames dut%0d", k), int'(st_fr[k]), exp_frames[k] % 65536);
    chk($sformatf("stat_escapes dut%0d", k), int'(st_esc[k]), exp_esc[k] % 65536);
  endtask

  task automatic chk_seq(input string name, input int t0, input int n);
    bit ok;
    ok = (hs_cyc.size() == n);
    foreach (hs_cyc[i]) if (hs_cyc[i] != t0 + 1 + i) ok = 1'b0;
    n_total++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: %0d bytes, first at cycle %0d, expected %0d back-to-back from cycle %0d",
               name, hs_cyc.size(), (hs_cyc.size() > 0) ? hs_cyc[0] : -1, n, t0 + 1);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge aclk) begin
    logic [7:0] e;
    if (!aresetn) begin
      for (int k = 0; k < 3; k++) prev_stall[k] = 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (prev_stall[k]) begin
          n_total++;
          if (!m_tvalid[k] || m_tdata[k] != prev_data[k]) begin
            n_bad++;
            $display("FAIL stall_hold dut%0d: got v=%0b d=%h expected v=1 d=%h",
                     k, m_tvalid[k], m_tdata[k], prev_data[k]);
          end
        end
        if (ESC_EN_K[k] && m_tvalid[k] && m_tdata[k] == 8'h7F) begin
          n_total++;
          if (s_tready[k]) begin
            n_bad++;
            $display("FAIL esc2_tready dut%0d: got target_tready=1 expected 0", k);
          end
        end
        if (m_tvalid[k] && m_ready[k]) begin
          n_total++;
          hs_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL out_byte dut%0d: got %h expected nothing", k, m_tdata[k]);
          end else begin
            e = exp_q.pop_front();
            if (e != m_tdata[k]) begin
              n_bad++;
              $display("FAIL out_byte dut%0d: got %h expected %h", k, m_tdata[k], e);
            end
          end
        end
        prev_stall[k] = m_tvalid[k] && !m_ready[k];
        prev_data[k]  = m_tdata[k];
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    m_ready = 3'b111;
    forever begin
      @(posedge aclk);
      #1;
      m_ready = rand_mode ? 3'($urandom_range(0, 7)) : 3'b111;
    end
  end

  task automatic send_beat(input int k, input logic [7:0] d, input logic last);
    bit hs;
    int n;
    s_tdata[k]  = d;
    s_tlast[k]  = last;
    s_tvalid[k] = 1'b1;
    hs = 1'b0;
    n = 0;
    while (!hs && n < 200) begin
      @(negedge aclk);
      hs = s_tready[k];
      @(posedge aclk);
      #1;
      n++;
    end
    s_tvalid[k] = 1'b0;
    if (!hs) begin
      n_total++;
      n_bad++;
      $display("FAIL beat_timeout dut%0d: got no handshake expected one within 200 cycles", k);
    end
  endtask

  task automatic send_pkt(input int k, input logic [7:0] tid, input bit gaps);
    push_frame(k, tid);
    s_tid[k] = tid;
    foreach (pkt[i]) begin
      if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge aclk); #1; end
      send_beat(k, pkt[i], i == pkt.size() - 1);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin @(posedge aclk); n++; end
    repeat (2) @(posedge aclk);
    #1;
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d bytes outstanding expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic apply_reset();
    aresetn = 1'b0;
    s_tvalid = '0;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin exp_frames[k] = 0; exp_esc[k] = 0; end
    #1;
  endtask

  task automatic release_reset();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t0, len;
    s_tlast = '0;
    for (int k = 0; k < 3; k++) begin s_tdata[k] = '0; s_tid[k] = '0; end
    apply_reset();
    chk("reset tvalid", int'(m_tvalid), 0);
    chk("reset tdata", int'(m_tdata[0]), 0);
    chk_stats(0);
    release_reset();

    pkt = '{8'h01, 8'h02, 8'h03};
    hs_cyc.delete(); t0 = cyc;
    send_pkt(0, 8'h0, 1'b0); drain();
    chk_seq("plain_frame_timing", t0, 5);
    chk_stats(0);

    pkt = '{8'h7D, 8'h7E, 8'h7F, 8'h55};
    hs_cyc.delete(); t0 = cyc;
    send_pkt(0, 8'h0, 1'b0); drain();
    chk_seq("escaped_frame_timing", t0, 9);
    chk_stats(0);

    pkt = '{8'h11};
    send_pkt(1, 8'h0A, 1'b0); drain();
    send_pkt(1, 8'h7E, 1'b0); drain();
    chk_stats(1);

    hs_cyc.delete(); t0 = cyc;
    pkt = '{8'hAA}; send_pkt(0, 8'h0, 1'b0);
    pkt = '{8'hBB}; send_pkt(0, 8'h0, 1'b0);
    drain();
    chk_seq("back_to_back", t0, 6);

    pkt = '{8'h7E}; send_pkt(2, 8'h0, 1'b0);
    pkt = '{8'h7D, 8'h7F, 8'h10}; send_pkt(2, 8'h0, 1'b0);
    drain();
    chk_stats(2);

    apply_reset();
    release_reset();
    rand_mode = 1'b1;
    for (int p = 0; p < 200; p++) begin
      pkt.delete();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++)
        pkt.push_back(($urandom_range(0, 3) == 0) ? 8'(8'h7C + $urandom_range(1, 3))
                                                   : 8'($urandom_range(0, 255)));
      send_pkt(0, 8'h0, 1'b1);
    end
    drain();
    rand_mode = 1'b0;
    chk("random stat_frames", int'(st_fr[0]), 200);
    chk_stats(0);

    pkt = '{8'h10, 8'h20, 8'h30, 8'h40};
    push_frame(0, 8'h0);
    send_beat(0, 8'h10, 1'b0);
    send_beat(0, 8'h20, 1'b0);
    apply_reset();
    chk("midreset tvalid", int'(m_tvalid[0]), 0);
    chk_stats(0);
    release_reset();
    pkt = '{8'h01};
    hs_cyc.delete(); t0 = cyc;
    send_pkt(0, 8'h0, 1'b0); drain();
    chk_seq("post_reset_frame", t0, 3);
    chk_stats(0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected finish before 2ms");
    $fatal(1);
  end

endmodule
